// File: rtl/sevenseg_pkg.sv
// Shared glyph constants and BCD-to-segment mapping for the display driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] nib
  );
    logic [6:0] g;
    case (nib)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decoder.sv
// Combinational nibble-to-glyph decoder; invalid BCD shows a dash.
// Shared by all digits through the scan mux.
module seg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_to_seg(nibble_i);

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed common-anode driver with frame latch, guard cycle
// and colon blink. Optional leading-zero blanking: SEVSEG_LZB_EN.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int COLON_DIV   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (COLON_DIV > 1) ? $clog2(COLON_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh_q, sh_d;
  logic [BW-1:0] bc_q, bc_d;
  logic          ph_q, ph_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic [3:0] nib;
  logic [6:0] glyph;
  logic       slot_end;
  logic       blink_end;
  logic       blank;

  assign nib = sh_q[{idx_q, 2'b00} +: 4];

  seg_decoder u_dec (
    .nibble_i (nib),
    .seg_o    (glyph)
  );

  assign slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
  assign blink_end = (bc_q == BW'(COLON_DIV - 1));

`ifdef SEVSEG_LZB_EN
  assign blank = (idx_q == 2'd3) && (nib == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;
    sh_d  = (slot_end && idx_q == 2'd3) ? bcd_in : sh_q;
    bc_d  = blink_end ? '0 : bc_q + 1'b1;
    ph_d  = blink_end ? ~ph_q : ph_q;
  end

  // cnt==0 is the dark guard cycle between digits
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = 4'hF;
    dp_d  = 1'b1;
    if (cnt_q != '0) begin
      if (!blank) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = glyph;
      end
      dp_d = ~((idx_q == 2'd2) && ph_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
      bc_q  <= '0;
      ph_q  <= 1'b1;
      seg_q <= SEG_OFF;
      an_q  <= 4'hF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      bc_q  <= bc_d;
      ph_q  <= ph_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Multiplexed four-digit seven-segment display driver that consumes the 16-bit HH:MM BCD word produced by the stopwatch and drives a common-anode display. It sits between the stopwatch output and the board pins, on the same slow (1 kHz) clock. It scans one digit at a time, latches the BCD word only at frame boundaries (no tearing), inserts an anode-off guard cycle per digit (no ghosting), and blinks the HH:MM colon.

## Interface
- REFRESH_DIV, 4: clk cycles per digit slot; legal range ≥2.
- COLON_DIV, 500: clk cycles per colon blink half-period; legal range ≥1.
- clk  input  1  slow system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- bcd_in  input  16  {H tens, H ones, M tens, M ones}, 4 bits each.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, active-low; an[0] = minutes ones, an[3] = hours tens.
- dp  output  1  decimal point, active-low; used as the colon on digit 2.

## Operation
- State:
  - slot counter cnt, range 0..REFRESH_DIV-1.
  - digit index idx, range 0..3.
  - 16-bit shadow register.
  - blink counter bc, range 0..COLON_DIV-1.
  - blink phase ph.
- Scan:
  - cnt increments every cycle. On wrap, idx increments modulo 4 (sequence 0→1→2→3→0).
- Frame latch: on the cycle where cnt==REFRESH_DIV-1 and idx==3, shadow <= bcd_in. bcd_in is ignored at all other times.
- Digit select: nibble = shadow[4*idx+3 : 4*idx].
- Decode:
  - Nibbles 0-9 map to standard glyphs, for example 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Nibbles 10-15 (invalid BCD) display a dash, 7'b0111111.
- Guard: while cnt==0, an = 4'b1111, seg = 7'b1111111 and dp = 1.
- Active drive: while cnt≥1, an has a single 0 at bit idx; seg shows the decoded nibble.
- Colon:
  - bc increments every cycle; ph toggles when bc wraps.
  - dp = 0 only when idx==2, cnt≥1 and ph==1. Otherwise dp = 1.
- Reset mid-scan: all counters clear and shadow = 0. Scanning restarts at idx 0, slot cycle 0, on the next cycle.

## Timing
- All outputs are registered and reflect the state (cnt, idx, shadow, ph) of the previous cycle. Latency from state to pins is 1 cycle.
- Reset values:
  - seg = 7'b1111111, an = 4'b1111, dp = 1.
  - cnt = 0, idx = 0, shadow = 16'h0000, bc = 0, ph = 1.
- Frame length is 4*REFRESH_DIV cycles (16 ms at 1 kHz with the defaults).
- A bcd_in change appears on the pins no earlier than the next frame. The worst case is 4*REFRESH_DIV+1 cycles after the change.
- Within a slot, cycle 0 is dark and cycles 1..REFRESH_DIV-1 are lit. The anode never switches directly from one digit to another without a dark cycle in between.
- The colon half-period is COLON_DIV cycles (0.5 s at the defaults). ph is sampled during slot 2 only.
- If the frame latch and a blink wrap fall on the same cycle, both updates take effect. They are independent.

## Configuration
- SEVSEG_LZB_EN (leading-zero blanking).
- Defined: during idx 3, if the hours-tens nibble == 0, an[3] stays high and seg = 7'b1111111 for the whole slot. For example, 16'h0905 displays " 9:05".
- Undefined: digit 3 is driven like every other digit, so 16'h0905 displays "09:05".
- The macro has no effect on timing or on any other digit.

## Structure
- Package sevenseg_pkg holds:
  - the glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF);
  - the digit-count constant (NUM_DIGITS = 4);
  - the BCD-to-segment function used by the decoder.
- Sub-module seg_decoder: combinational 4-bit nibble to 7-bit active-low glyph. It is instantiated once, on the muxed nibble.
- The top level holds the counters, the shadow register, the output registers and the blanking logic.

## Test plan
- Reset release:
  - With rst held, seg = 7'h7F, an = 4'hF and dp = 1.
  - After release, slot 0 first lights an = 4'b1110 with seg = 7'b1000000 (shadow = 0).
- Scan order:
  - Stimulus: bcd_in = 16'h1234, wait one full frame.
  - Expect an = 1110/1101/1011/0111 showing 4/3/2/1.
  - Expect a dark an = 4'hF cycle before each digit.
  - Expect each digit lit for 3 of every 4 cycles.
- Frame latch:
  - Stimulus: change bcd_in from 16'h1234 to 16'h5678 mid-frame.
  - Expect the current frame to finish showing 1234.
  - Expect the next frame to show 8,7,6,5.
- Invalid BCD: bcd_in = 16'h0A0F → the digit 0 and digit 2 slots show seg = 7'b0111111.
- Colon blink:
  - Expect dp low during lit slot-2 cycles for 500 cycles, then high for 500.
  - Expect dp never low in slots 0, 1 or 3.
- Blanking: bcd_in = 16'h0905.
  - With SEVSEG_LZB_EN, the slot-3 an stays 4'hF.
  - Without it, an[3] = 0 and seg = 7'b1000000 during slot 3.
